// File: rtl/cmd_sched_queue.sv
// Timed-command scheduler: holds up to DEPTH {time, payload} commands and presents
// the earliest command that is still in the future, purging stale entries while scanning.
module cmd_sched_queue #(
  parameter int DEPTH = 256,
  parameter int TW    = 64,
  parameter int PW    = 274,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          CLK,
  input  logic          rst_n,
  input  logic [TW-1:0] TIME,
  input  logic          TIME_UPDATE,
  input  logic          CLR_ALL,
  input  logic          WR_REQ,
  input  logic [TW-1:0] WR_TIME,
  input  logic [PW-1:0] WR_PAYLOAD,
  input  logic          REQ_COMM,
  output logic          DATA_WR,
  output logic          OUT_VALID,
  output logic [TW-1:0] OUT_TIME,
  output logic [PW-1:0] OUT_PAYLOAD,
  output logic          WR_ERR,
  output logic          STALE_DROP,
  output logic          FULL,
  output logic [AW:0]   COUNT,
  output logic          BUSY
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WRITE  = 3'd1;
  localparam logic [2:0] S_DELETE = 3'd2;
  localparam logic [2:0] S_SCAN   = 3'd3;
  localparam logic [2:0] S_FETCH  = 3'd4;
  localparam logic [2:0] S_LOAD   = 3'd5;

  localparam logic [AW:0] LAST_CNT = (AW+1)'(DEPTH);
  localparam int RW = TW + PW;

  function automatic logic [AW:0] popcount(input logic [DEPTH-1:0] v);
    logic [AW:0] c;
    c = {(AW+1){1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      c = c + {{AW{1'b0}}, v[i]};
    end
    return c;
  endfunction

  function automatic logic [AW-1:0] lowest_free(input logic [DEPTH-1:0] v);
    logic [AW-1:0] idx;
    idx = {AW{1'b0}};
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!v[i]) begin
        idx = i[AW-1:0];
      end
    end
    return idx;
  endfunction

  logic [2:0]       state_r, state_nxt_s;
  logic [DEPTH-1:0] valid_r, valid_nxt_s;
  logic [AW:0]      count_r;
  logic             full_r;
  logic             out_valid_r, data_wr_r, wr_err_r, stale_r, busy_r;
  logic [TW-1:0]    out_time_r;
  logic [PW-1:0]    out_payload_r;

  logic             wr_pend_r, req_pend_r, clr_pend_r, rescan_pend_r, tu_d_r;
  logic             wr_pend_nxt_s, req_pend_nxt_s, clr_pend_nxt_s, rescan_pend_nxt_s;
  logic [TW-1:0]    wr_time_r;
  logic [PW-1:0]    wr_payload_r;

  logic [TW-1:0]    t0_r;
  logic [AW:0]      scan_cnt_r, scan_cnt_nxt_s;
  logic             ev_en_r;
  logic [AW-1:0]    ev_idx_r;
  logic             found_r, found_nxt_s;
  logic [TW-1:0]    best_time_r, best_time_nxt_s;
  logic [AW-1:0]    best_idx_r, best_idx_nxt_s;
  logic [AW-1:0]    sel_r;

  logic [RW-1:0]    mem_r [DEPTH];
  logic [RW-1:0]    rd_data_r;
  logic [AW-1:0]    rd_addr_s, free_idx_s;
  logic [TW-1:0]    rd_time_s;
  logic             mem_we_s, scan_start_s, load_s, out_clr_s;
  logic             wr_nxt_err_s, stale_nxt_s;
  logic             wr_evt_s, req_evt_s, clr_evt_s, rescan_evt_s;

  // Events seen this cycle count as pending, so a pulse in IDLE is acted on at once.
  assign wr_evt_s     = wr_pend_r | WR_REQ;
  assign req_evt_s    = req_pend_r | REQ_COMM;
  assign clr_evt_s    = clr_pend_r | CLR_ALL;
  assign rescan_evt_s = rescan_pend_r | (TIME_UPDATE & ~tu_d_r);

  assign rd_time_s    = rd_data_r[RW-1:PW];
  assign free_idx_s   = lowest_free(valid_r);
  assign rd_addr_s    = (state_r == S_FETCH) ? best_idx_r :
                        ((scan_cnt_r < LAST_CNT) ? scan_cnt_r[AW-1:0] : {AW{1'b0}});
  assign scan_start_s = (state_nxt_s == S_SCAN) && (state_r != S_SCAN);

  // Next-state, slot-valid and pending-flag logic
  always_comb begin
    state_nxt_s       = state_r;
    valid_nxt_s       = valid_r;
    wr_pend_nxt_s     = wr_evt_s;
    req_pend_nxt_s    = req_evt_s;
    clr_pend_nxt_s    = clr_evt_s;
    rescan_pend_nxt_s = rescan_evt_s;
    scan_cnt_nxt_s    = scan_cnt_r;
    found_nxt_s       = found_r;
    best_time_nxt_s   = best_time_r;
    best_idx_nxt_s    = best_idx_r;
    mem_we_s          = 1'b0;
    load_s            = 1'b0;
    out_clr_s         = 1'b0;
    wr_nxt_err_s      = 1'b0;
    stale_nxt_s       = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (clr_evt_s) begin
          valid_nxt_s       = {DEPTH{1'b0}};
          out_clr_s         = 1'b1;
          wr_pend_nxt_s     = 1'b0;
          req_pend_nxt_s    = 1'b0;
          clr_pend_nxt_s    = 1'b0;
          rescan_pend_nxt_s = 1'b0;
        end else if (req_evt_s) begin
          req_pend_nxt_s = 1'b0;
          if (out_valid_r) begin
            state_nxt_s = S_DELETE;
          end else begin
            state_nxt_s = S_IDLE;
          end
        end else if (wr_evt_s) begin
          wr_pend_nxt_s = 1'b0;
          if (full_r) begin
            wr_nxt_err_s = 1'b1;
          end else begin
            state_nxt_s = S_WRITE;
          end
        end else if (rescan_evt_s) begin
          rescan_pend_nxt_s = 1'b0;
          state_nxt_s       = S_SCAN;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_WRITE: begin
        mem_we_s                = 1'b1;
        valid_nxt_s[free_idx_s] = 1'b1;
        state_nxt_s             = S_SCAN;
      end
      S_DELETE: begin
        valid_nxt_s[sel_r] = 1'b0;
        out_clr_s          = 1'b1;
        state_nxt_s        = S_SCAN;
      end
      S_SCAN: begin
        scan_cnt_nxt_s = scan_cnt_r + {{AW{1'b0}}, 1'b1};
        // Data for the slot addressed last cycle arrives now; strict < keeps the lowest index on ties.
        if (ev_en_r && valid_r[ev_idx_r]) begin
          if (rd_time_s > t0_r) begin
            if (!found_r || (rd_time_s < best_time_r)) begin
              found_nxt_s     = 1'b1;
              best_time_nxt_s = rd_time_s;
              best_idx_nxt_s  = ev_idx_r;
            end else begin
              found_nxt_s = found_r;
            end
          end else begin
            valid_nxt_s[ev_idx_r] = 1'b0;
            stale_nxt_s           = 1'b1;
          end
        end else begin
          stale_nxt_s = 1'b0;
        end
        if (scan_cnt_r == LAST_CNT) begin
          if (found_nxt_s) begin
            state_nxt_s = S_FETCH;
          end else begin
            state_nxt_s = S_IDLE;
            out_clr_s   = 1'b1;
          end
        end else begin
          state_nxt_s = S_SCAN;
        end
      end
      S_FETCH: begin
        state_nxt_s = S_LOAD;
      end
      S_LOAD: begin
        load_s      = 1'b1;
        state_nxt_s = S_IDLE;
      end
      default: begin
        state_nxt_s = S_IDLE;
      end
    endcase
  end

  // Control, scan and output registers
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= S_IDLE;
      valid_r       <= {DEPTH{1'b0}};
      count_r       <= {(AW+1){1'b0}};
      full_r        <= 1'b0;
      out_valid_r   <= 1'b0;
      out_time_r    <= {TW{1'b0}};
      out_payload_r <= {PW{1'b0}};
      data_wr_r     <= 1'b0;
      wr_err_r      <= 1'b0;
      stale_r       <= 1'b0;
      busy_r        <= 1'b0;
      wr_pend_r     <= 1'b0;
      req_pend_r    <= 1'b0;
      clr_pend_r    <= 1'b0;
      rescan_pend_r <= 1'b0;
      tu_d_r        <= 1'b0;
      wr_time_r     <= {TW{1'b0}};
      wr_payload_r  <= {PW{1'b0}};
      t0_r          <= {TW{1'b0}};
      scan_cnt_r    <= {(AW+1){1'b0}};
      ev_en_r       <= 1'b0;
      ev_idx_r      <= {AW{1'b0}};
      found_r       <= 1'b0;
      best_time_r   <= {TW{1'b0}};
      best_idx_r    <= {AW{1'b0}};
      sel_r         <= {AW{1'b0}};
    end else begin
      state_r       <= state_nxt_s;
      valid_r       <= valid_nxt_s;
      count_r       <= popcount(valid_nxt_s);
      full_r        <= &valid_nxt_s;
      data_wr_r     <= load_s;
      wr_err_r      <= wr_nxt_err_s;
      stale_r       <= stale_nxt_s;
      busy_r        <= (state_nxt_s != S_IDLE);
      wr_pend_r     <= wr_pend_nxt_s;
      req_pend_r    <= req_pend_nxt_s;
      clr_pend_r    <= clr_pend_nxt_s;
      rescan_pend_r <= rescan_pend_nxt_s;
      tu_d_r        <= TIME_UPDATE;
      ev_en_r       <= (state_r == S_SCAN) && (scan_cnt_r < LAST_CNT);
      ev_idx_r      <= rd_addr_s;
      best_time_r   <= best_time_nxt_s;
      best_idx_r    <= best_idx_nxt_s;
      if (WR_REQ) begin
        wr_time_r    <= WR_TIME;
        wr_payload_r <= WR_PAYLOAD;
      end else begin
        wr_time_r    <= wr_time_r;
        wr_payload_r <= wr_payload_r;
      end
      if (scan_start_s) begin
        t0_r       <= TIME;
        scan_cnt_r <= {(AW+1){1'b0}};
        found_r    <= 1'b0;
      end else begin
        t0_r       <= t0_r;
        scan_cnt_r <= scan_cnt_nxt_s;
        found_r    <= found_nxt_s;
      end
      if (load_s) begin
        out_valid_r   <= 1'b1;
        out_time_r    <= rd_time_s;
        out_payload_r <= rd_data_r[PW-1:0];
        sel_r         <= best_idx_r;
      end else if (out_clr_s) begin
        out_valid_r   <= 1'b0;
      end else begin
        out_valid_r   <= out_valid_r;
      end
    end
  end

  // Command storage: simple dual-port RAM with one-cycle registered read
  always_ff @(posedge CLK) begin
    if (mem_we_s) begin
      mem_r[free_idx_s] <= {wr_time_r, wr_payload_r};
    end
    rd_data_r <= mem_r[rd_addr_s];
  end

  assign DATA_WR     = data_wr_r;
  assign OUT_VALID   = out_valid_r;
  assign OUT_TIME    = out_time_r;
  assign OUT_PAYLOAD = out_payload_r;
  assign WR_ERR      = wr_err_r;
  assign STALE_DROP  = stale_r;
  assign FULL        = full_r;
  assign COUNT       = count_r;
  assign BUSY        = busy_r;

endmodule

// File: tb/tb_cmd_sched_queue.sv
// Scoreboard bench for cmd_sched_queue (DEPTH=8): directed stimulus pushes expected
// presented commands; a negedge monitor pops and compares on every DATA_WR.
module tb_cmd_sched_queue;
  localparam int DEPTH = 8;
  localparam int TW    = 64;
  localparam int PW    = 32;
  localparam int AW    = $clog2(DEPTH);

  logic          CLK = 1'b0;
  logic          rst_n = 1'b0;
  logic [TW-1:0] TIME = 64'd10;
  logic          TIME_UPDATE = 1'b0;
  logic          CLR_ALL = 1'b0;
  logic          WR_REQ = 1'b0;
  logic [TW-1:0] WR_TIME = 64'd0;
  logic [PW-1:0] WR_PAYLOAD = 32'd0;
  logic          REQ_COMM = 1'b0;
  logic          DATA_WR, OUT_VALID, WR_ERR, STALE_DROP, FULL, BUSY;
  logic [TW-1:0] OUT_TIME;
  logic [PW-1:0] OUT_PAYLOAD;
  logic [AW:0]   COUNT;

  always #5 CLK = ~CLK;

  cmd_sched_queue #(.DEPTH(DEPTH), .TW(TW), .PW(PW)) dut (
    .CLK(CLK), .rst_n(rst_n), .TIME(TIME), .TIME_UPDATE(TIME_UPDATE),
    .CLR_ALL(CLR_ALL), .WR_REQ(WR_REQ), .WR_TIME(WR_TIME), .WR_PAYLOAD(WR_PAYLOAD),
    .REQ_COMM(REQ_COMM), .DATA_WR(DATA_WR), .OUT_VALID(OUT_VALID), .OUT_TIME(OUT_TIME),
    .OUT_PAYLOAD(OUT_PAYLOAD), .WR_ERR(WR_ERR), .STALE_DROP(STALE_DROP), .FULL(FULL),
    .COUNT(COUNT), .BUSY(BUSY)
  );

  typedef struct packed {
    logic [TW-1:0] t;
    logic [PW-1:0] p;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   err_seen = 0;
  int   stale_seen = 0;
  logic mon_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: compare each presented command against the scoreboard
  always @(negedge CLK) begin
    if (mon_en) begin
      if (WR_ERR) err_seen++;
      if (STALE_DROP) stale_seen++;
      if (DATA_WR) begin
        check("data_wr_expected", (exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          check("out_time", OUT_TIME, mon_e.t);
          check("out_payload", OUT_PAYLOAD, mon_e.p);
          check("out_valid_on_data_wr", OUT_VALID, 64'd1);
        end
      end
    end
  end

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((BUSY === 1'b1) && (n < 200)) begin
      @(negedge CLK);
      n++;
    end
    check({name, "_idle_bound"}, (n < 200), 64'd1);
    @(negedge CLK);
  endtask

  task automatic do_write(input logic [TW-1:0] t, input logic [PW-1:0] p);
    WR_TIME = t;
    WR_PAYLOAD = p;
    WR_REQ = 1'b1;
    @(negedge CLK);
    WR_REQ = 1'b0;
    wait_idle("write");
  endtask

  task automatic do_req();
    REQ_COMM = 1'b1;
    @(negedge CLK);
    REQ_COMM = 1'b0;
    wait_idle("req");
  endtask

  task automatic do_clr();
    CLR_ALL = 1'b1;
    @(negedge CLK);
    CLR_ALL = 1'b0;
    @(negedge CLK);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    repeat (3) @(negedge CLK);
    check("rst_data_wr", DATA_WR, 64'd0);
    check("rst_out_valid", OUT_VALID, 64'd0);
    check("rst_count", COUNT, 64'd0);
    check("rst_full", FULL, 64'd0);
    check("rst_busy", BUSY, 64'd0);
    check("rst_wr_err", WR_ERR, 64'd0);
    check("rst_stale", STALE_DROP, 64'd0);
    rst_n = 1'b1;
    mon_en = 1'b1;
    @(negedge CLK);

    // 1: first write, measured latency DEPTH+5
    exp_q.push_back({64'd100, 32'd1});
    WR_TIME = 64'd100;
    WR_PAYLOAD = 32'd1;
    WR_REQ = 1'b1;
    lat = 0;
    while (lat < 100) begin
      @(posedge CLK);
      lat++;
      @(negedge CLK);
      WR_REQ = 1'b0;
      if (DATA_WR) break;
    end
    check("latency", lat, DEPTH + 5);
    wait_idle("t1a");
    exp_q.push_back({64'd50, 32'd2});
    do_write(64'd50, 32'd2);
    exp_q.push_back({64'd50, 32'd2});
    do_write(64'd300, 32'd3);
    check("t1_out_time", OUT_TIME, 64'd50);
    check("t1_count", COUNT, 64'd3);
    check("t1_out_valid", OUT_VALID, 64'd1);

    // 2: consume the presented command
    exp_q.push_back({64'd100, 32'd1});
    do_req();
    check("t2_out_time", OUT_TIME, 64'd100);
    check("t2_count", COUNT, 64'd2);

    // 3: fill and overflow
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back({64'd100, 32'd1});
      do_write(64'd400 + 64'(i) * 64'd100, 32'd4 + 32'(i));
    end
    check("t3_count_full", COUNT, 64'd8);
    check("t3_full", FULL, 64'd1);
    do_write(64'd20, 32'd99);
    check("t3_wr_err", err_seen, 64'd1);
    check("t3_count_after", COUNT, 64'd8);
    check("t3_out_time", OUT_TIME, 64'd100);
    check("t3_out_payload", OUT_PAYLOAD, 64'd1);
    do_clr();
    check("clr_count", COUNT, 64'd0);
    check("clr_full", FULL, 64'd0);
    check("clr_out_valid", OUT_VALID, 64'd0);

    // 4: forward time jump purges a stale entry
    exp_q.push_back({64'd100, 32'd11});
    do_write(64'd100, 32'd11);
    exp_q.push_back({64'd100, 32'd11});
    do_write(64'd200, 32'd12);
    exp_q.push_back({64'd200, 32'd12});
    TIME = 64'd150;
    TIME_UPDATE = 1'b1;
    repeat (3) @(negedge CLK);
    TIME_UPDATE = 1'b0;
    wait_idle("t4");
    check("t4_stale", stale_seen, 64'd1);
    check("t4_count", COUNT, 64'd1);
    check("t4_out_time", OUT_TIME, 64'd200);
    do_clr();

    // 5: rescan of an empty queue, then tie resolution
    TIME = 64'd10;
    TIME_UPDATE = 1'b1;
    @(negedge CLK);
    TIME_UPDATE = 1'b0;
    wait_idle("t5_empty");
    check("t5_empty_out_valid", OUT_VALID, 64'd0);
    exp_q.push_back({64'd500, 32'd20});
    do_write(64'd500, 32'd20);
    exp_q.push_back({64'd500, 32'd20});
    do_write(64'd600, 32'd21);
    exp_q.push_back({64'd70, 32'd22});
    do_write(64'd70, 32'd22);
    exp_q.push_back({64'd70, 32'd22});
    do_write(64'd800, 32'd23);
    exp_q.push_back({64'd70, 32'd22});
    do_write(64'd900, 32'd24);
    exp_q.push_back({64'd70, 32'd22});
    do_write(64'd70, 32'd25);
    check("t5_tie_payload", OUT_PAYLOAD, 64'd22);
    exp_q.push_back({64'd70, 32'd25});
    do_req();
    check("t5_next_time", OUT_TIME, 64'd70);
    check("t5_next_payload", OUT_PAYLOAD, 64'd25);
    check("t5_count", COUNT, 64'd5);

    // 6: CLR_ALL wins over simultaneous WR_REQ and REQ_COMM
    WR_TIME = 64'd1000;
    WR_PAYLOAD = 32'd77;
    CLR_ALL = 1'b1;
    WR_REQ = 1'b1;
    REQ_COMM = 1'b1;
    @(negedge CLK);
    CLR_ALL = 1'b0;
    WR_REQ = 1'b0;
    REQ_COMM = 1'b0;
    repeat (DEPTH + 10) @(negedge CLK);
    check("t6_count", COUNT, 64'd0);
    check("t6_out_valid", OUT_VALID, 64'd0);
    check("t6_busy", BUSY, 64'd0);
    check("t6_wr_err", err_seen, 64'd1);

    check("exp_q_drained", exp_q.size(), 64'd0);
    check("stale_total", stale_seen, 64'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
